// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory stage with data-memory handshake, redirect resolution and MEM/WB latch
module mem_wb_stage #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WORD_W-1:0] rdat2_i,
    input  logic [WORD_W-1:0] imm_i,
    input  logic [WORD_W-1:0] pc4_i,
    input  logic [WORD_W-1:0] jaddr_i,
    input  logic [WORD_W-1:0] branchaddr_i,
    input  logic [WORD_W-1:0] OutputPort_i,
    input  logic [REG_W-1:0]  wsel_i,
    input  logic              RegWr_i,
    input  logic              halt_i,
    input  logic              dREN_i,
    input  logic              dWEN_i,
    input  logic              ZeroFlag_i,
    input  logic [1:0]        MemToReg_i,
    input  logic [1:0]        PCsrc_i,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic              redirect,
    output logic [WORD_W-1:0] redirect_pc,
    output logic              flush,
    output logic [REG_W-1:0]  wb_wsel,
    output logic              wb_RegWr,
    output logic [WORD_W-1:0] wb_wdat,
    output logic              wb_halt,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_WAIT   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t             state_q;
    logic [REG_W-1:0]   wsel_q;
    logic               regwr_q;
    logic [WORD_W-1:0]  wdat_q;
    logic [WORD_W-1:0]  wdat_d;
    logic               halt_q;
    logic [CNT_W-1:0]   stall_q;
    logic [CNT_W-1:0]   stall_d;
    logic               halted;
    logic               mem_op;
    logic               done;

    assign halted    = (state_q == S_HALTED);
    assign mem_op    = dREN_i | dWEN_i;
    // A simultaneous read and write request is illegal; the write is kept.
    assign dmemWEN   = ~halted & dWEN_i;
    assign dmemREN   = ~halted & dREN_i & ~dWEN_i;
    assign dmemaddr  = OutputPort_i;
    assign dmemstore = rdat2_i;
    assign mem_stall = mem_op & ~dhit & ~halted;
    assign done      = ~halted & ~mem_stall;

    always_comb begin
        redirect    = 1'b0;
        redirect_pc = '0;
        if (done) begin
            unique case (PCsrc_i)
                2'b01: begin
                    redirect    = ZeroFlag_i;
                    redirect_pc = ZeroFlag_i ? branchaddr_i : '0;
                end
                2'b10: begin
                    redirect    = ~ZeroFlag_i;
                    redirect_pc = ZeroFlag_i ? '0 : branchaddr_i;
                end
                2'b11: begin
                    redirect    = 1'b1;
                    redirect_pc = jaddr_i;
                end
                default: begin
                    redirect    = 1'b0;
                    redirect_pc = '0;
                end
            endcase
        end
    end

    assign flush = redirect;

    always_comb begin
        wdat_d = OutputPort_i;
        unique case (MemToReg_i)
            2'b01:   wdat_d = dmemload;
            2'b10:   wdat_d = pc4_i;
            2'b11:   wdat_d = imm_i;
            default: wdat_d = OutputPort_i;
        endcase
    end

    // Saturating count of stalled cycles.
    assign stall_d = (mem_stall && (stall_q != {CNT_W{1'b1}})) ? stall_q + 1'b1 : stall_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_RUN;
            wsel_q  <= '0;
            regwr_q <= 1'b0;
            wdat_q  <= '0;
            halt_q  <= 1'b0;
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
            unique case (state_q)
                S_RUN, S_WAIT: begin
                    if (done) begin
                        wsel_q  <= wsel_i;
                        wdat_q  <= wdat_d;
                        regwr_q <= RegWr_i & ~halt_i;
                        if (halt_i) begin
                            halt_q  <= 1'b1;
                            state_q <= S_HALTED;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end else begin
                        regwr_q <= 1'b0;
                        state_q <= S_WAIT;
                    end
                end
                S_HALTED: state_q <= S_HALTED;
                default:  state_q <= S_RUN;
            endcase
        end
    end

    assign wb_wsel      = wsel_q;
    assign wb_RegWr     = regwr_q;
    assign wb_wdat      = wdat_q;
    assign wb_halt      = halt_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed scoreboard bench for mem_wb_stage
module tb_mem_wb_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] rdat2_i, imm_i, pc4_i, jaddr_i, branchaddr_i, OutputPort_i;
    logic [4:0]  wsel_i;
    logic        RegWr_i, halt_i, dREN_i, dWEN_i, ZeroFlag_i;
    logic [1:0]  MemToReg_i, PCsrc_i;
    logic        dhit;
    logic [31:0] dmemload;
    logic        dmemREN, dmemWEN, mem_stall, redirect, flush;
    logic [31:0] dmemaddr, dmemstore, redirect_pc, wb_wdat;
    logic [4:0]  wb_wsel;
    logic        wb_RegWr, wb_halt;
    logic [15:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] wdat;
        logic [4:0]  wsel;
        logic        regwr;
        logic        halt;
    } wb_t;

    wb_t sb[$];

    mem_wb_stage #(.WORD_W(32), .REG_W(5), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST),
        .rdat2_i(rdat2_i), .imm_i(imm_i), .pc4_i(pc4_i), .jaddr_i(jaddr_i),
        .branchaddr_i(branchaddr_i), .OutputPort_i(OutputPort_i), .wsel_i(wsel_i),
        .RegWr_i(RegWr_i), .halt_i(halt_i), .dREN_i(dREN_i), .dWEN_i(dWEN_i),
        .ZeroFlag_i(ZeroFlag_i), .MemToReg_i(MemToReg_i), .PCsrc_i(PCsrc_i),
        .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .mem_stall(mem_stall), .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
        .wb_wsel(wb_wsel), .wb_RegWr(wb_RegWr), .wb_wdat(wb_wdat), .wb_halt(wb_halt),
        .stall_cycles(stall_cycles)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        rdat2_i = '0; imm_i = '0; pc4_i = '0; jaddr_i = '0; branchaddr_i = '0;
        OutputPort_i = '0; wsel_i = '0; RegWr_i = 0; halt_i = 0; dREN_i = 0;
        dWEN_i = 0; ZeroFlag_i = 0; MemToReg_i = 2'b00; PCsrc_i = 2'b00;
        dhit = 0; dmemload = '0;
    endtask

    // Inputs must already be driven (at posedge+1); dhit rises after hit_after wait cycles.
    task automatic issue(input int hit_after, input logic [31:0] load_val);
        wb_t         e;
        wb_t         got;
        logic        stall_x, redir_x;
        logic [31:0] rpc_x;
        bit          fin;
        unique case (MemToReg_i)
            2'b01:   e.wdat = load_val;
            2'b10:   e.wdat = pc4_i;
            2'b11:   e.wdat = imm_i;
            default: e.wdat = OutputPort_i;
        endcase
        e.wsel  = wsel_i;
        e.regwr = RegWr_i & ~halt_i;
        e.halt  = halt_i;
        sb.push_back(e);
        fin = 0;
        for (int cyc = 0; cyc < 20 && !fin; cyc++) begin
            dhit     = (cyc >= hit_after);
            dmemload = dhit ? load_val : 32'h0;
            #3;
            stall_x = (dREN_i | dWEN_i) & ~dhit;
            redir_x = 1'b0;
            rpc_x   = '0;
            if (!stall_x) begin
                if (PCsrc_i == 2'b01 && ZeroFlag_i) begin redir_x = 1; rpc_x = branchaddr_i; end
                if (PCsrc_i == 2'b10 && !ZeroFlag_i) begin redir_x = 1; rpc_x = branchaddr_i; end
                if (PCsrc_i == 2'b11) begin redir_x = 1; rpc_x = jaddr_i; end
            end
            chk("mem_stall", {31'b0, mem_stall}, {31'b0, stall_x});
            chk("dmemREN", {31'b0, dmemREN}, {31'b0, dREN_i & ~dWEN_i});
            chk("dmemWEN", {31'b0, dmemWEN}, {31'b0, dWEN_i});
            chk("dmemaddr", dmemaddr, OutputPort_i);
            chk("dmemstore", dmemstore, rdat2_i);
            chk("redirect", {31'b0, redirect}, {31'b0, redir_x});
            chk("flush", {31'b0, flush}, {31'b0, redir_x});
            chk("redirect_pc", redirect_pc, rpc_x);
            step();
            if (!stall_x) begin
                fin = 1;
                got = sb.pop_front();
                chk("wb_wdat", wb_wdat, got.wdat);
                chk("wb_wsel", {27'b0, wb_wsel}, {27'b0, got.wsel});
                chk("wb_RegWr", {31'b0, wb_RegWr}, {31'b0, got.regwr});
                chk("wb_halt", {31'b0, wb_halt}, {31'b0, got.halt});
            end else begin
                chk("bubble_RegWr", {31'b0, wb_RegWr}, 32'h0);
            end
        end
        if (!fin) chk("issue_timeout", 32'h1, 32'h0);
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        RST = 1;
        step();
        step();
        chk("rst_wb_wdat", wb_wdat, 32'h0);
        chk("rst_wb_RegWr", {31'b0, wb_RegWr}, 32'h0);
        chk("rst_wb_halt", {31'b0, wb_halt}, 32'h0);
        chk("rst_stall_cycles", {16'b0, stall_cycles}, 32'h0);
        RST = 0;

        // ALU result
        OutputPort_i = 32'h0000_0010; MemToReg_i = 2'b00; RegWr_i = 1; wsel_i = 5'd5;
        issue(0, 32'h0);

        // load, three wait cycles
        OutputPort_i = 32'h0000_0100; dREN_i = 1; MemToReg_i = 2'b01; RegWr_i = 1; wsel_i = 5'd9;
        issue(3, 32'hDEAD_BEEF);
        chk("stall_after_load", {16'b0, stall_cycles}, 32'd3);

        // zero-wait store
        OutputPort_i = 32'h0000_0200; rdat2_i = 32'h0000_1234; dWEN_i = 1; wsel_i = 5'd3;
        issue(0, 32'h0);

        // illegal read+write: write wins, one wait cycle
        OutputPort_i = 32'h0000_0300; rdat2_i = 32'hA5A5_0001; dWEN_i = 1; dREN_i = 1;
        issue(1, 32'h0);

        // BEQ taken, BNE not taken, jump with pc4 link, LUI
        PCsrc_i = 2'b01; ZeroFlag_i = 1; branchaddr_i = 32'h40; OutputPort_i = 32'h7;
        issue(0, 32'h0);
        PCsrc_i = 2'b10; ZeroFlag_i = 1; branchaddr_i = 32'h44;
        issue(0, 32'h0);
        PCsrc_i = 2'b10; ZeroFlag_i = 0; branchaddr_i = 32'h48;
        issue(0, 32'h0);
        PCsrc_i = 2'b11; jaddr_i = 32'h80; pc4_i = 32'h1C; MemToReg_i = 2'b10;
        RegWr_i = 1; wsel_i = 5'd31;
        issue(0, 32'h0);
        MemToReg_i = 2'b11; imm_i = 32'hABCD_0000; RegWr_i = 1; wsel_i = 5'd7;
        issue(0, 32'h0);
        chk("stall_total", {16'b0, stall_cycles}, 32'd4);

        // halt, then confirm everything stays frozen
        halt_i = 1; RegWr_i = 1; wsel_i = 5'd2; OutputPort_i = 32'h55;
        issue(0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            dREN_i = 1; dhit = 0; OutputPort_i = 32'h900 + i; PCsrc_i = 2'b11;
            jaddr_i = 32'hC0; RegWr_i = 1; wsel_i = 5'd12;
            #3;
            chk("halted_dmemREN", {31'b0, dmemREN}, 32'h0);
            chk("halted_mem_stall", {31'b0, mem_stall}, 32'h0);
            chk("halted_redirect", {31'b0, redirect}, 32'h0);
            step();
            chk("halted_wb_halt", {31'b0, wb_halt}, 32'h1);
            chk("halted_wb_wdat", wb_wdat, 32'h55);
            chk("halted_wb_RegWr", {31'b0, wb_RegWr}, 32'h0);
        end
        chk("halted_stall_cycles", {16'b0, stall_cycles}, 32'd4);

        // reset out of halt, then reset during a pending load
        clear_inputs();
        RST = 1;
        step();
        RST = 0;
        chk("rst2_wb_halt", {31'b0, wb_halt}, 32'h0);
        OutputPort_i = 32'h0000_0400; dREN_i = 1; MemToReg_i = 2'b01; RegWr_i = 1; wsel_i = 5'd4;
        step();
        step();
        chk("wait_stall", {31'b0, mem_stall}, 32'h1);
        chk("wait_stall_cycles", {16'b0, stall_cycles}, 32'd2);
        RST = 1;
        clear_inputs();
        step();
        RST = 0;
        chk("rstwait_wb_wdat", wb_wdat, 32'h0);
        chk("rstwait_wb_wsel", {27'b0, wb_wsel}, 32'h0);
        chk("rstwait_wb_RegWr", {31'b0, wb_RegWr}, 32'h0);
        chk("rstwait_stall_cycles", {16'b0, stall_cycles}, 32'h0);
        chk("rstwait_dmemREN", {31'b0, dmemREN}, 32'h0);

        // back in RUN: single-cycle ALU latency
        OutputPort_i = 32'h0000_0077; RegWr_i = 1; wsel_i = 5'd6;
        issue(0, 32'h0);
        chk("scoreboard_empty", sb.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Memory stage plus MEM/WB latch of the 5-stage pipeline. It consumes the latched EX/MEM outputs and drives the data-memory request handshake, stalling upstream until dhit. It resolves branch and jump redirects and registers write-back data and control for the register file. A sticky halt state and a stall-cycle counter are included.

Parameters:
WORD_W, 32, datapath word width
REG_W, 5, register-select width
CNT_W, 16, width of stall-cycle counter (saturating)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous active-high reset
rdat2_i  in  WORD_W  store data
imm_i  in  WORD_W  extended immediate (LUI value)
pc4_i  in  WORD_W  PC+4 of instruction
jaddr_i  in  WORD_W  jump/JR target
branchaddr_i  in  WORD_W  branch target
OutputPort_i  in  WORD_W  ALU result / memory address
wsel_i  in  REG_W  destination register
RegWr_i, halt_i, dREN_i, dWEN_i, ZeroFlag_i  in  1 each  latched control
MemToReg_i  in  2  00 ALU, 01 load, 10 pc4, 11 imm
PCsrc_i  in  2  00 seq, 01 BEQ, 10 BNE, 11 jump (jaddr_i)
dhit  in  1  data memory handshake complete
dmemload  in  WORD_W  load data, valid when dhit
dmemREN, dmemWEN  out  1  data memory request
dmemaddr, dmemstore  out  WORD_W  request address / store data
mem_stall  out  1  hold EX/MEM and all upstream latches
redirect  out  1  PC must load redirect_pc
redirect_pc  out  WORD_W  redirect target
flush  out  1  flush IF/ID and ID/EX latches
wb_wsel  out  REG_W  registered destination
wb_RegWr  out  1  registered write enable
wb_wdat  out  WORD_W  registered write data
wb_halt  out  1  registered, sticky halt
stall_cycles  out  CNT_W  count of cycles with mem_stall=1

Behaviour:
- FSM states RUN, WAIT, HALTED. Reset -> RUN; all registered outputs 0; stall_cycles 0.
- mem_op = dREN_i | dWEN_i. In RUN/WAIT: dmemREN = dREN_i, dmemWEN = dWEN_i (combinational from inputs), dmemaddr = OutputPort_i, dmemstore = rdat2_i. In HALTED: dmemREN = dmemWEN = 0.
- dREN_i and dWEN_i both 1 is illegal; write wins (dmemREN forced 0).
- mem_stall = mem_op & ~dhit & state != HALTED. RUN with mem_stall -> WAIT; WAIT holds request unchanged until dhit -> RUN. dhit in RUN completes the access with no stall (zero-wait).
- Completion (done) = state != HALTED & ~mem_stall. Only on done does the MEM/WB latch update; while stalled it holds, except wb_RegWr is forced 0 (bubble).
- wb_wdat on done: per MemToReg_i -> OutputPort_i / dmemload / pc4_i / imm_i. wb_wsel = wsel_i, wb_RegWr = RegWr_i.
- Redirect (combinational, gated by done): PCsrc 01 and ZeroFlag_i -> branchaddr_i; 10 and ~ZeroFlag_i -> branchaddr_i; 11 -> jaddr_i. Else redirect = 0, redirect_pc = 0. flush = redirect.
- Halt: done & halt_i -> next state HALTED, wb_halt = 1, wb_RegWr = 0. HALTED is left only by RST; no requests, no redirects, mem_stall = 0, latch frozen.
- stall_cycles increments each cycle mem_stall = 1; saturates at 2^CNT_W-1; cleared only by RST.
- RST during WAIT: next cycle state RUN, request deasserted if inputs are cleared by upstream reset; counter and latch zeroed; pending access is abandoned.
- Latency: non-memory instruction reaches wb_* 1 cycle after presentation; load with dhit after N wait cycles reaches wb_* N+1 cycles after presentation.

Test Plan:
- ALU op: OutputPort_i=0x0000_0010, MemToReg=00, RegWr=1, wsel=5 -> next edge wb_wdat=0x10, wb_wsel=5, wb_RegWr=1, mem_stall=0.
- Load, dhit after 3 cycles, dmemload=0xDEAD_BEEF, addr 0x100 -> dmemREN=1 and dmemaddr=0x100 for 4 cycles, mem_stall=1 for 3, wb_RegWr=0 while stalled, then wb_wdat=0xDEADBEEF; stall_cycles=3.
- Store, dhit same cycle, rdat2_i=0x1234 -> dmemWEN=1, dmemstore=0x1234, no stall, wb_RegWr=0.
- BEQ ZeroFlag=1 branchaddr=0x40 -> redirect=1, flush=1, redirect_pc=0x40; BNE ZeroFlag=1 -> redirect=0; jump jaddr=0x80 -> redirect_pc=0x80.
- halt_i=1 -> wb_halt=1 next edge, stays 1 with following dREN_i=1 inputs and dmemREN=0 until RST.
- RST asserted in WAIT mid-load -> next cycle state RUN, wb_* = 0, stall_cycles = 0.
